dsp_mac_seq: RTL
================

Name: dsp_mac_seq

Overview:
Sequencer that drives the shared 18x18/48-bit DSP slice (DSP module) as a multiply-accumulate engine. It accepts a job of N signed operand pairs over a valid/ready stream and emits the OPMODE, operand, clock-enable and register-reset controls to the DSP. It absorbs the DSP pipeline latency and returns the 48-bit dot product on a valid/ready result port. It sits between a job master and one DSP instance configured with B_INPUT="DIRECT".

Parameters:
LEN_W, 16, width of job length (pairs per job)
DSP_LAT, 3, cycles from DSP A/B/OPMODE inputs to P (A1REG+MREG+PREG)
OPM_SKEW, 1, cycles dsp_opmode is delayed relative to dsp_a/dsp_b so it meets the post-adder together with its product

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
start  in  1  job request; sampled only in IDLE
len  in  LEN_W  pair count, latched on start
busy  out  1  high in every state except IDLE
op_valid  in  1  operand pair valid
op_ready  out  1  high only in RUN
op_a  in  18  signed multiplicand
op_b  in  18  signed multiplier
dsp_a  out  18  to DSP A
dsp_b  out  18  to DSP B
dsp_opmode  out  8  to DSP OPMODE
dsp_ce  out  1  drives all DSP CE inputs
dsp_rst  out  1  drives all DSP RST inputs, active high
dsp_p  in  48  from DSP P
res_valid  out  1  result valid
res_data  out  48  dot product
res_ready  in  1  result accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, op_ready, dsp_ce, res_valid=0; dsp_rst=0; dsp_a, dsp_b, res_data=0; dsp_opmode=8'h00; skew line and counters cleared. Reset mid-job abandons the job; no result is produced.
- OPMODE codes: FIRST=8'b0000_0001 (X=M, Z=0); ACC=8'b0000_1001 (X=M, Z=P); HOLD=8'b0000_1000 (X=0, Z=P). Pre-adder is bypassed; CARRYIN=0.
- IDLE:
  - start with len!=0: latch len, go to CLR.
  - start with len==0: go to DONE with res_data=0.
  - start is ignored in every other state.
- CLR: one cycle; dsp_rst=1, dsp_ce=1. Go to RUN.
- RUN: op_ready=1, dsp_ce=1.
  - Each op_valid&&op_ready: register dsp_a<=op_a and dsp_b<=op_b; the opmode entering the skew line is FIRST for pair 0 and ACC for later pairs; pair count increments.
  - Cycle without a transfer: dsp_a and dsp_b hold; HOLD enters the skew line. P is unchanged.
  - Acceptance of pair len-1 moves to DRAIN.
- DRAIN: HOLD enters the skew line; dsp_ce=1 for DSP_LAT+OPM_SKEW cycles; then capture res_data<=dsp_p and go to DONE.
- DONE: res_valid=1, res_data stable; busy=1. res_ready=1 returns to IDLE the next cycle. res_valid and res_ready may already be high together on DONE entry.
- Timing: if the last pair is accepted at cycle t, res_valid rises at t+DSP_LAT+OPM_SKEW+2.
- Arithmetic: signed 18x18 products are sign-extended to 48 bits and accumulated modulo 2^48. There is no overflow flag.

Optional Feature:
DSPSEQ_SUB_EN
- Defined: adds input port op_sub (1 bit, qualified with op_valid). A pair with op_sub=1 is subtracted by setting OPMODE[7]: FIRST becomes 8'b1000_0001 (P = 0 - M) and ACC becomes 8'b1000_1001.
- Undefined: no op_sub port; every pair is added.

Decomposition:
- Package dsp_seq_pkg:
  - state enum {IDLE, CLR, RUN, DRAIN, DONE}
  - OPM_FIRST, OPM_ACC, OPM_HOLD and OPM_SUB_BIT=7
  - DSP width constants A_W=18, P_W=48
- One sub-module dsp_opm_delay: OPM_SKEW-deep 8-bit shift register, reset to HOLD.
- FSM, counters and result register are in dsp_mac_seq.

Test Plan:
- len=3, pairs (3,4),(5,6),(7,8) back-to-back -> res_data=98, res_valid at t_last+DSP_LAT+OPM_SKEW+2.
- Same job with op_valid low for 2 cycles between each pair -> res_data=98; no extra accumulation during bubbles.
- op_a=18'h3FFFE (-2), op_b=5, len=1 -> res_data=48'hFFFF_FFFF_FFF6.
- len=0 start -> DONE next cycle, res_data=0, no dsp_rst pulse; hold res_ready=0 for 5 cycles -> res_valid and data held, start pulses ignored; then res_ready=1 -> IDLE.
- Two jobs back-to-back, (2,3) then (4,4) -> results 6 then 16. Verifies CLR wipes P between jobs.
- rst_n low during RUN after 2 of 4 pairs -> all outputs at reset values immediately; new job (1,1) -> 1. With DSPSEQ_SUB_EN, (10,10,add),(3,4,sub) -> 88.

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared state encoding, DSP OPMODE codes and DSP port widths for the MAC sequencer.
package dsp_seq_pkg;
  localparam int A_W = 18;
  localparam int P_W = 48;
  localparam int OPM_SUB_BIT = 7;
  localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
  localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
  localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;
  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/dsp_mac_seq_if.sv
// dsp_mac_seq_if: job request, operand stream and result stream between a job master and the MAC sequencer.
// op_sub exists only when DSPSEQ_SUB_EN is defined.
interface dsp_mac_seq_if #(parameter int LEN_W = 16);
  import dsp_seq_pkg::*;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             op_valid;
  logic             op_ready;
  logic [A_W-1:0]   op_a;
  logic [A_W-1:0]   op_b;
`ifdef DSPSEQ_SUB_EN
  logic             op_sub;
`endif
  logic             res_valid;
  logic [P_W-1:0]   res_data;
  logic             res_ready;
  modport master (
`ifdef DSPSEQ_SUB_EN
    output op_sub,
`endif
    output start, len, op_valid, op_a, op_b, res_ready,
    input  busy, op_ready, res_valid, res_data
  );
  modport slave (
`ifdef DSPSEQ_SUB_EN
    input  op_sub,
`endif
    input  start, len, op_valid, op_a, op_b, res_ready,
    output busy, op_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp_opm_delay.sv
// dsp_opm_delay: DEPTH-stage OPMODE shift register, reset to HOLD, aligning OPMODE with its product at the DSP post-adder.
module dsp_opm_delay
  import dsp_seq_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] opm_i,
  output logic [7:0] opm_o
);
  logic [DEPTH-1:0][7:0] sr_q, sr_d;
  always_comb begin
    sr_d[0] = opm_i;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= {DEPTH{OPM_HOLD}};
    else sr_q <= sr_d;
  end
  assign opm_o = sr_q[DEPTH-1];
endmodule

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: drives one DSP slice as a dot-product MAC engine; job in over valid/ready, 48-bit result out.
// Defining DSPSEQ_SUB_EN adds per-pair subtraction through bus.op_sub.
module dsp_mac_seq
  import dsp_seq_pkg::*;
#(
  parameter int LEN_W    = 16,
  parameter int DSP_LAT  = 3,
  parameter int OPM_SKEW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dsp_mac_seq_if.slave     bus,
  output logic [A_W-1:0]   dsp_a,
  output logic [A_W-1:0]   dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [P_W-1:0]   dsp_p
);
  localparam int DRAIN_N = DSP_LAT + OPM_SKEW;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [A_W-1:0]   a_q, a_d, b_q, b_d;
  logic [7:0]       opm_q, opm_d, opm_dly;
  logic [P_W-1:0]   res_q, res_d;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    opm_d   = OPM_HOLD;
    res_d   = res_q;
    case (state_q)
      IDLE: if (bus.start) begin
        len_d   = bus.len;
        cnt_d   = '0;
        res_d   = '0;
        state_d = (bus.len == '0) ? DONE : CLR;
      end
      CLR: state_d = RUN;
      RUN: if (bus.op_valid) begin
        a_d   = bus.op_a;
        b_d   = bus.op_b;
        opm_d = (cnt_q == '0) ? OPM_FIRST : OPM_ACC;
`ifdef DSPSEQ_SUB_EN
        opm_d[OPM_SUB_BIT] = bus.op_sub;
`endif
        cnt_d   = (cnt_q == len_q - LEN_W'(1)) ? '0 : cnt_q + LEN_W'(1);
        state_d = (cnt_q == len_q - LEN_W'(1)) ? DRAIN : RUN;
      end
      // P is final after DRAIN_N clocked cycles; the extra cycle captures it with the DSP frozen.
      DRAIN: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == LEN_W'(DRAIN_N)) begin
          res_d   = dsp_p;
          state_d = DONE;
        end
      end
      DONE: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opm_q   <= OPM_HOLD;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opm_q   <= opm_d;
      res_q   <= res_d;
    end
  end
  dsp_opm_delay #(.DEPTH(OPM_SKEW)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .opm_i (opm_q),
    .opm_o (opm_dly)
  );
  assign dsp_ce = (state_q == CLR) || (state_q == RUN) ||
                  (state_q == DRAIN && cnt_q < LEN_W'(DRAIN_N));
  assign dsp_rst       = state_q == CLR;
  assign dsp_a         = a_q;
  assign dsp_b         = b_q;
  assign dsp_opmode    = dsp_ce ? opm_dly : 8'h00;
  assign bus.busy      = state_q != IDLE;
  assign bus.op_ready  = state_q == RUN;
  assign bus.res_valid = state_q == DONE;
  assign bus.res_data  = res_q;
endmodule
